// File: rtl/mem_access_unit.sv
// Load/store stage: turns datapath memory ops into a req/ack word bus transaction.
// Optional macro MEM_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES unacked REQ cycles.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misalign,
  output logic        timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // Bus handshake: bus_req rises with the registered request and holds it
  // unchanged until the cycle bus_ack=1; ack in any other cycle is ignored.

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  state_t state;

  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic        mis_c;
  logic [31:0] load_c;
  logic [15:0] half_c;
  logic [7:0]  byte_c;

  // Lane masks, replicated store data and alignment fault for the incoming op.
  always_comb begin
    be_c  = 4'b1111;
    wd_c  = wdata;
    mis_c = 1'b0;
    case (op)
      OP_LW, OP_SW: mis_c = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: begin
        mis_c = addr[0];
        be_c  = addr[1] ? 4'b1100 : 4'b0011;
        wd_c  = {2{wdata[15:0]}};
      end
      default: begin
        be_c = 4'b0001 << addr[1:0];
        wd_c = {4{wdata[7:0]}};
      end
    endcase
  end

  always_comb begin
    half_c = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    byte_c = bus_rdata[{lane_q, 3'b000} +: 8];
    case (op_q)
      OP_LH:   load_c = {{16{half_c[15]}}, half_c};
      OP_LHU:  load_c = {16'h0000, half_c};
      OP_LB:   load_c = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  load_c = {24'h000000, byte_c};
      default: load_c = bus_rdata;
    endcase
  end

  assign stall = !rst && (((state == IDLE) && start) || (state == REQ));

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rdata     <= '0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      timeout   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      op_q      <= '0;
      lane_q    <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mis_c) begin
              state    <= ERR;
              done     <= 1'b1;
              misalign <= 1'b1;
              rdata    <= '0;
            end else begin
              state     <= REQ;
              bus_req   <= 1'b1;
              bus_we    <= op[2] && (op != OP_LBU);
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= be_c;
              bus_wdata <= wd_c;
              op_q      <= op;
              lane_q    <= addr[1:0];
`ifdef MEM_TIMEOUT_EN
              cnt       <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            done    <= 1'b1;
            if (!bus_we) rdata <= load_c;
          end
`ifdef MEM_TIMEOUT_EN
          // An ack on the limit cycle takes the branch above and completes normally.
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state   <= DONE;
            bus_req <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            rdata   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit, checked against an arithmetic model.
module tb_mem_access_unit;

  logic        clka = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall, done, misalign, timeout;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd = '0;

  always #5 clka = ~clka;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clka(clka), .rst(rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .done(done), .misalign(misalign), .timeout(timeout),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes drives alignment, lanes and replication.
  function automatic int unsigned m_size(input logic [2:0] o);
    if (o == 3'd0 || o == 3'd5) return 4;
    if (o == 3'd1 || o == 3'd2 || o == 3'd6) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] o, input int unsigned lane,
                                         input logic [31:0] w);
    int unsigned v;
    case (o)
      3'd1, 3'd2: begin
        v = (w >> (16 * (lane / 2))) & 32'hFFFF;
        if (o == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
      end
      3'd3, 3'd4: begin
        v = (w >> (8 * lane)) & 32'hFF;
        if (o == 3'd3 && v >= 128) v = v + 32'hFFFFFF00;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int delay);
    int unsigned sz, lane;
    logic [31:0] e_wd;
    logic [3:0] e_be;
    sz = m_size(o);
    lane = a % 4;
    e_be = 4'(((1 << sz) - 1) << lane);
    e_wd = (sz == 4) ? wd : (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001
                                      : (wd & 32'hFF) * 32'h01010101;
    bus_ack = 1'b0;
    op = o; addr = a; wdata = wd; start = 1'b1;
    #1 check("stall_c0", 32'(stall), 32'd1);
    @(negedge clka);
    #1;
    start = 1'b0;
    if (a % sz != 0) begin
      exp_rd = '0;
      check("err_done", 32'(done), 32'd1);
      check("err_misalign", 32'(misalign), 32'd1);
      check("err_bus_req", 32'(bus_req), 32'd0);
      check("err_stall", 32'(stall), 32'd0);
      check("err_rdata", rdata, exp_rd);
    end else begin
      for (int i = 0; i <= delay; i++) begin
        check("req_bus_req", 32'(bus_req), 32'd1);
        check("req_we", 32'(bus_we), 32'(o >= 3'd5));
        check("req_addr", bus_addr, a & 32'hFFFFFFFC);
        check("req_be", 32'(bus_be), 32'(e_be));
        if (o >= 3'd5) check("req_wdata", bus_wdata, e_wd);
        check("req_stall", 32'(stall), 32'd1);
        check("req_done", 32'(done), 32'd0);
        start = 1'($urandom_range(0, 1));
        op = 3'($urandom); addr = $urandom;
        if (i == delay) begin
          bus_ack = 1'b1; bus_rdata = rd;
        end else begin
          bus_ack = 1'b0; bus_rdata = $urandom;
        end
        @(negedge clka);
        #1;
      end
      bus_ack = 1'b0; start = 1'b0;
      if (o < 3'd5) exp_rd = m_load(o, lane, rd);
      check("done_pulse", 32'(done), 32'd1);
      check("done_misalign", 32'(misalign), 32'd0);
      check("done_timeout", 32'(timeout), 32'd0);
      check("done_bus_req", 32'(bus_req), 32'd0);
      check("done_stall", 32'(stall), 32'd0);
      check("done_rdata", rdata, exp_rd);
    end
    @(negedge clka);
    bus_ack = 1'($urandom_range(0, 1));
    #1;
    check("idle_done", 32'(done), 32'd0);
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_rdata", rdata, exp_rd);
  endtask

  initial begin
    #2;
    check("rst_rdata", rdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clka);
    rst = 1'b0;
    @(negedge clka);

    run_op(3'd0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    run_op(3'd3, 32'h103, 32'h0, 32'h80FF0000, 0);
    run_op(3'd4, 32'h103, 32'h0, 32'h80FF0000, 1);
    run_op(3'd1, 32'h102, 32'h0, 32'h80FF0000, 0);
    run_op(3'd7, 32'h201, 32'h12345678, 32'h0, 3);
    run_op(3'd5, 32'h302, 32'h11111111, 32'h0, 0);
    run_op(3'd2, 32'h001, 32'h0, 32'h0, 0);

    // Reset in the middle of an LW request.
    bus_ack = 1'b0; op = 3'd0; addr = 32'h400; start = 1'b1;
    @(negedge clka);
    #1;
    start = 1'b0;
    check("mid_req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(bus_req), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    @(negedge clka);
    rst = 1'b0;
    exp_rd = '0;
    repeat (2) begin
      @(negedge clka);
      #1;
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_req", 32'(bus_req), 32'd0);
    end
    run_op(3'd6, 32'h10, 32'h0000AABB, 32'h0, 0);

`ifdef MEM_TIMEOUT_EN
    bus_ack = 1'b0; op = 3'd0; addr = 32'h40; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clka);
      #1;
      start = 1'b0;
      check("to_req", 32'(bus_req), 32'd1);
    end
    @(negedge clka);
    #1;
    exp_rd = '0;
    check("to_done", 32'(done), 32'd1);
    check("to_flag", 32'(timeout), 32'd1);
    check("to_bus_req", 32'(bus_req), 32'd0);
    check("to_rdata", rdata, exp_rd);
    @(negedge clka);
`else
    run_op(3'd0, 32'h40, 32'h0, 32'hCAFEF00D, 120);
`endif

    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
